// File: rtl/nes_oam_dma_if.sv
// nes_oam_dma_if: CPU-side inputs (cpu_addr/cpu_dout/cpu_rw_n), arbitrated bus (bus_addr/bus_dout/bus_rw_n/bus_din) and status (cpu_rdy/dma_active)
interface nes_oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic cpu_rw_n;
  logic cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0] bus_dout;
  logic bus_rw_n;
  logic [7:0] bus_din;
  logic dma_active;
  modport master(output cpu_addr, cpu_dout, cpu_rw_n, bus_din, input cpu_rdy, bus_addr, bus_dout, bus_rw_n, dma_active);
  modport slave(input cpu_addr, cpu_dout, cpu_rw_n, bus_din, output cpu_rdy, bus_addr, bus_dout, bus_rw_n, dma_active);
endinterface

// File: rtl/nes_oam_dma.sv
// nes_oam_dma: sprite DMA + CPU bus arbiter; clk/rst (async high), io.slave carries cpu_* in, bus_* out, bus_din in, cpu_rdy/dma_active out
module nes_oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic clk,
  input logic rst,
  nes_oam_dma_if.slave io
);
  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
  state_t state, state_n;
  logic [7:0] page, idx, data_q;
  logic cyc_par;
  logic trig;
  assign trig = state == IDLE && !io.cpu_rw_n && io.cpu_addr == DMA_REG_ADDR;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      page <= '0;
      idx <= '0;
      data_q <= '0;
      cyc_par <= 1'b0;
    end else begin
      state <= state_n;
      cyc_par <= ~cyc_par;
      if (trig) begin
        page <= io.cpu_dout;
        idx <= '0;
      end
      if (state == READ) data_q <= io.bus_din;
      if (state == WRITE) idx <= idx + 8'd1;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = trig ? HALT : IDLE;
      HALT: state_n = cyc_par ? READ : ALIGN;
      ALIGN: state_n = READ;
      READ: state_n = WRITE;
      WRITE: state_n = idx == 8'hff ? IDLE : READ;
      default: state_n = IDLE;
    endcase
  end
  assign io.cpu_rdy = state == IDLE;
  assign io.dma_active = state != IDLE;
  assign io.bus_addr = state == READ ? {page, idx} : state == WRITE ? OAM_DATA_ADDR : io.cpu_addr;
  assign io.bus_rw_n = state == IDLE ? io.cpu_rw_n : state != WRITE;
  assign io.bus_dout = state == WRITE ? data_q : io.cpu_dout;
endmodule

// File: tb/tb_nes_oam_dma.sv
// tb_nes_oam_dma: random-stimulus scoreboard bench for nes_oam_dma against a transfer-level reference model
module tb_nes_oam_dma;
  typedef struct {
    logic hold;
    logic [15:0] addr;
    logic rw;
    logic [7:0] data;
  } op_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] mem [65536];
  int cyc;
  int vecs = 0;
  int errs = 0;
  int stall = 0;
  int wr_cnt = 0;
  op_t exp_q[$];
  int stall_q[$];
  nes_oam_dma_if io();
  nes_oam_dma dut(.clk(clk), .rst(rst), .io(io.slave));
  always #5 clk = ~clk;
  assign io.bus_din = mem[io.bus_addr];
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push_dma(input logic [7:0] p, input logic par);
    int h = par ? 2 : 1;
    op_t o;
    for (int i = 0; i < h; i++) begin
      o = '{1'b1, 16'h0, 1'b1, 8'h0};
      exp_q.push_back(o);
    end
    for (int k = 0; k < 256; k++) begin
      o = '{1'b0, {p, 8'(k)}, 1'b1, 8'h0};
      exp_q.push_back(o);
      o = '{1'b0, 16'h2004, 1'b0, mem[{p, 8'(k)}]};
      exp_q.push_back(o);
    end
    stall_q.push_back(512 + h);
  endtask
  task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
    io.cpu_addr = a;
    io.cpu_dout = d;
    io.cpu_rw_n = rw;
    if (!rw && a == 16'h4014) push_dma(d, cyc[0]);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!io.cpu_rdy && n < 600) begin
      drive(16'($urandom), 8'($urandom), 1'b1);
      n++;
    end
    if (n >= 600) chk("dma_timeout", 0, 1);
  endtask
  task automatic set_par(input logic par);
    if (cyc[0] != par) drive(16'h0123, 8'h00, 1'b1);
  endtask
  task automatic passthrough(input int n);
    logic [15:0] a;
    logic rw;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0: a = 16'h4015;
        1: a = 16'h4013;
        2: a = 16'h4014;
        default: a = 16'($urandom);
      endcase
      rw = 1'($urandom);
      if (a == 16'h4014) rw = 1'b1;
      drive(a, 8'($urandom), rw);
    end
  endtask
  always @(negedge clk) begin
    op_t e;
    if (rst) stall = 0;
    else if (io.dma_active) begin
      stall++;
      chk("dma_cpu_rdy", int'(io.cpu_rdy), 0);
      if (exp_q.size() == 0) chk("unexpected_dma_cycle", int'(io.bus_addr), -1);
      else begin
        e = exp_q.pop_front();
        if (e.hold) begin
          wr_cnt = 0;
          chk("hold_addr", int'(io.bus_addr), int'(io.cpu_addr));
          chk("hold_rw", int'(io.bus_rw_n), 1);
        end else begin
          chk(e.rw ? "read_addr" : "write_addr", int'(io.bus_addr), int'(e.addr));
          chk("dma_rw", int'(io.bus_rw_n), int'(e.rw));
          if (!e.rw) begin
            chk("write_data", int'(io.bus_dout), int'(e.data));
            wr_cnt++;
          end
        end
      end
    end else begin
      chk("idle_cpu_rdy", int'(io.cpu_rdy), 1);
      chk("pass_addr", int'(io.bus_addr), int'(io.cpu_addr));
      chk("pass_rw", int'(io.bus_rw_n), int'(io.cpu_rw_n));
      chk("pass_dout", int'(io.bus_dout), int'(io.cpu_dout));
      if (stall > 0) begin
        chk("stall_len", stall, stall_q.size() ? stall_q.pop_front() : -1);
        stall = 0;
      end
    end
  end
  initial begin
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0700 + i] = 8'(i) ^ 8'ha5;
    io.cpu_addr = 16'h4014;
    io.cpu_dout = 8'h02;
    io.cpu_rw_n = 1'b0;
    #12;
    chk("reset_cpu_rdy", int'(io.cpu_rdy), 1);
    chk("reset_dma_active", int'(io.dma_active), 0);
    chk("reset_pass_rw", int'(io.bus_rw_n), 0);
    io.cpu_rw_n = 1'b1;
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    passthrough(60);
    set_par(1'b0);
    drive(16'h4014, 8'h02, 1'b0);
    wait_idle();
    passthrough(5);
    set_par(1'b1);
    drive(16'h4014, 8'h02, 1'b0);
    wait_idle();
    set_par(1'b0);
    drive(16'h4014, 8'h07, 1'b0);
    wait_idle();
    drive(16'h4014, 8'h03, 1'b0);
    wait_idle();
    passthrough(10);
    drive(16'h4014, 8'h05, 1'b0);
    n = 0;
    while (wr_cnt < 101 && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 600) chk("reset_wait_timeout", 0, 1);
    io.cpu_addr = 16'h0055;
    io.cpu_rw_n = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_cpu_rdy", int'(io.cpu_rdy), 1);
    chk("midrst_dma_active", int'(io.dma_active), 0);
    chk("midrst_rw", int'(io.bus_rw_n), 0);
    chk("midrst_addr", int'(io.bus_addr), 16'h0055);
    exp_q.delete();
    stall_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    passthrough(40);
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("stall_queue_drained", stall_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
